// File: rtl/awgn_pkg.sv
// rtl/awgn_pkg.sv - shared sizes, Q4.4 gain format and scheduler state encoding
package awgn_pkg;

  localparam int SAMPLE_W_DFLT = 16;
  localparam int LEN_W_DFLT    = 16;
  localparam int WARMUP_DFLT   = 8;
  localparam int GAIN_W        = 8;
  localparam int FRAC_BITS     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_FETCH,
    ST_EMIT0,
    ST_EMIT1,
    ST_FIN
  } state_e;

endpackage

// File: rtl/awgn_burst_scheduler_if.sv
// rtl/awgn_burst_scheduler_if.sv - serialised sample stream between scheduler and consumer
interface awgn_burst_scheduler_if #(
  parameter int SAMPLE_W = 16
);

  logic [SAMPLE_W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/awgn_gain_sat.sv
// rtl/awgn_gain_sat.sv - combinational Q4.4 gain: (x*gain)>>>4, saturated to SAMPLE_W
module awgn_gain_sat
  import awgn_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DFLT
) (
  input  logic [SAMPLE_W-1:0] x,
  input  logic [GAIN_W-1:0]   gain,
  output logic [SAMPLE_W-1:0] y
);

  // One guard bit above the full product so the unsigned gain never flips the sign.
  localparam int PW = SAMPLE_W + GAIN_W + 1;
  localparam logic signed [PW-1:0] MAXV = {{(PW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic signed [PW-1:0] xs;
  logic signed [PW-1:0] gs;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shr;

  always_comb begin
    xs   = {{(PW-SAMPLE_W){x[SAMPLE_W-1]}}, x};
    gs   = {{(PW-GAIN_W){1'b0}}, gain};
    prod = xs * gs;
    shr  = prod >>> FRAC_BITS;
    if (shr > MAXV) begin
      y = MAXV[SAMPLE_W-1:0];
    end else if (shr < MINV) begin
      y = MINV[SAMPLE_W-1:0];
    end else begin
      y = shr[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/awgn_burst_scheduler.sv
// rtl/awgn_burst_scheduler.sv - warms up the AWGN core and serialises (x0,x1) pairs into a burst
// AWGN_GAIN_EN adds the gain port and applies Q4.4 gain with saturation at pair capture.
module awgn_burst_scheduler
  import awgn_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DFLT,
  parameter int LEN_W    = LEN_W_DFLT,
  parameter int WARMUP   = WARMUP_DFLT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [LEN_W-1:0]    burst_len,
  output logic                core_en,
  input  logic [SAMPLE_W-1:0] core_x0,
  input  logic [SAMPLE_W-1:0] core_x1,
  output logic                busy,
  output logic                done,
`ifdef AWGN_GAIN_EN
  input  logic [GAIN_W-1:0]   gain,
`endif
  awgn_burst_scheduler_if.master out_if
);

  localparam int WC_W = $clog2(WARMUP + 1);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [WC_W-1:0]     warm_q, warm_d;
  logic [SAMPLE_W-1:0] x1_r, x1_d;
  logic [SAMPLE_W-1:0] out_data_q, out_data_d;
  logic                core_en_q, core_en_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [SAMPLE_W-1:0] x0_cap, x1_cap;
  logic                hs;

`ifdef AWGN_GAIN_EN
  logic [GAIN_W-1:0] gain_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gain_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      gain_q <= gain;
    end
  end

  awgn_gain_sat #(.SAMPLE_W(SAMPLE_W)) u_sat0 (.x(core_x0), .gain(gain_q), .y(x0_cap));
  awgn_gain_sat #(.SAMPLE_W(SAMPLE_W)) u_sat1 (.x(core_x1), .gain(gain_q), .y(x1_cap));
`else
  assign x0_cap = core_x0;
  assign x1_cap = core_x1;
`endif

  assign hs = out_valid_q & out_if.out_ready;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    warm_d     = warm_q;
    x1_d       = x1_r;
    out_data_d = out_data_q;
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rem_d = burst_len;
            if (burst_len != '0) begin
              state_d = ST_WARMUP;
              warm_d  = WC_W'(WARMUP - 1);
            end else begin
              state_d = ST_FIN;
            end
          end
        end
        ST_WARMUP: begin
          if (warm_q == '0) begin
            state_d = ST_FETCH;
          end else begin
            warm_d = warm_q - WC_W'(1);
          end
        end
        // The output register doubles as the x0 holding register during EMIT0.
        ST_FETCH: begin
          out_data_d = x0_cap;
          x1_d       = x1_cap;
          state_d    = ST_EMIT0;
        end
        ST_EMIT0: begin
          if (hs) begin
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_d = ST_FIN;
            end else begin
              state_d    = ST_EMIT1;
              out_data_d = x1_r;
            end
          end
        end
        ST_EMIT1: begin
          if (hs) begin
            rem_d   = rem_q - LEN_W'(1);
            state_d = (rem_q == LEN_W'(1)) ? ST_FIN : ST_FETCH;
          end
        end
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    // Outputs are decoded from the next state so they leave the flops aligned with it.
    core_en_d   = (state_d == ST_WARMUP) || (state_d == ST_FETCH);
    out_valid_d = (state_d == ST_EMIT0) || (state_d == ST_EMIT1);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      warm_q      <= '0;
      x1_r        <= '0;
      out_data_q  <= '0;
      core_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      warm_q      <= warm_d;
      x1_r        <= x1_d;
      out_data_q  <= out_data_d;
      core_en_q   <= core_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign core_en          = core_en_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;

endmodule
